// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle add/subtract built from one carry-lookahead chunk slice
module cla_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int NG = CHUNK / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_s;
    logic             w_acc;
    logic             w_term;
    logic             w_pall;
    logic [WIDTH-1:0] w_res;
    logic             w_last;
    int               w_base;

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    assign w_base = int'(r_idx) * CHUNK;
    assign w_ca   = r_opa[w_base +: CHUNK];
    assign w_cb   = r_opb[w_base +: CHUNK];
    assign w_last = (r_idx == IW'(N - 1));

    // Chunk adder: every carry inside a 4-bit group is a flat sum of products of that
    // group's g/p and the group carry-in; only group carry-outs chain to the next group.
    always_comb begin
        w_g    = w_ca & w_cb;
        w_p    = w_ca ^ w_cb;
        w_c    = '0;
        w_c[0] = r_carry;
        w_acc  = 1'b0;
        w_term = 1'b0;
        w_pall = 1'b0;
        for (int grp = 0; grp < NG; grp++) begin
            for (int j = 0; j < 4; j++) begin
                w_acc  = 1'b0;
                w_pall = 1'b1;
                for (int k = 0; k <= j; k++) begin
                    w_term = w_g[grp*4+k];
                    for (int m = k + 1; m <= j; m++) begin
                        w_term = w_term & w_p[grp*4+m];
                    end
                    w_acc  = w_acc | w_term;
                    w_pall = w_pall & w_p[grp*4+k];
                end
                w_c[grp*4+j+1] = w_acc | (w_pall & w_c[grp*4]);
            end
        end
        w_s = w_p ^ w_c[CHUNK-1:0];
    end

    // Full result as it will look once the current chunk is written back.
    always_comb begin
        w_res                  = r_result;
        w_res[w_base +: CHUNK] = w_s;
    end

    // Control FSM and datapath registers: capture, one chunk per RUN cycle, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result <= w_res;
                    if (w_last) begin
                        r_cout  <= w_c[CHUNK];
                        r_ovf   <= w_c[CHUNK] ^ w_c[CHUNK-1];
                        r_zero  <= ~|w_res;
                        r_state <= S_DONE;
                    end else begin
                        r_carry <= w_c[CHUNK];
                        r_idx   <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - randomized self-checking bench for cla_seq_adder (N=4 and N=1 instances)
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv0, iv1;
    logic        sub;
    logic        ordy;
    logic [31:0] a, b;

    logic        ir0, ov0, co0, of0, z0;
    logic        ir1, ov1, co1, of1, z1;
    logic [31:0] s0, s1;

    int          cur;
    logic        m_ir, m_ov, m_co, m_of, m_z;
    logic [31:0] m_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(32), .CHUNK(8)) u_n4 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .sub(sub),
        .out_valid(ov0), .out_ready(ordy), .sum(s0), .cout(co0), .ovf(of0), .zero(z0)
    );

    cla_seq_adder #(.WIDTH(32), .CHUNK(32)) u_n1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .sub(sub),
        .out_valid(ov1), .out_ready(ordy), .sum(s1), .cout(co1), .ovf(of1), .zero(z1)
    );

    always_comb begin
        m_ir  = (cur == 1) ? ir1 : ir0;
        m_ov  = (cur == 1) ? ov1 : ov0;
        m_sum = (cur == 1) ? s1  : s0;
        m_co  = (cur == 1) ? co1 : co0;
        m_of  = (cur == 1) ? of1 : of0;
        m_z   = (cur == 1) ? z1  : z0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (dut%0d): got %h expected %h", tag, cur, got, exp);
        end
    endtask

    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] es, output logic ec, output logic eo, output logic ez);
        logic [32:0] wide;
        if (!s) begin
            wide = {1'b0, x} + {1'b0, y};
            es   = wide[31:0];
            ec   = wide[32];
            eo   = (x[31] == y[31]) && (es[31] != x[31]);
        end else begin
            es = x - y;
            ec = (x >= y);
            eo = (x[31] != y[31]) && (es[31] != x[31]);
        end
        ez = (es == 32'd0);
    endtask

    task automatic set_iv(input logic v);
        if (cur == 1) iv1 = v; else iv0 = v;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!m_ir && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_wait", 32'(m_ir), 32'd1);
    endtask

    task automatic run_op(input int sel, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input int hold);
        logic [31:0] es;
        logic        ec, eo, ez;
        int          cycles;
        cur = sel;
        wait_ready();
        a = x; b = y; sub = s;
        set_iv(1'b1);
        @(posedge clk); #1;
        set_iv(1'b0);
        a = $urandom; b = $urandom; sub = 1'($urandom);
        cycles = 1;
        while (!m_ov && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", 32'(cycles), (sel == 1) ? 32'd2 : 32'd5);
        model(x, y, s, es, ec, eo, ez);
        check("sum", m_sum, es);
        check("cout", 32'(m_co), 32'(ec));
        check("ovf", 32'(m_of), 32'(eo));
        check("zero", 32'(m_z), 32'(ez));
        ordy = 1'b0;
        for (int h = 0; h < hold; h++) begin
            a = $urandom; b = $urandom;
            set_iv(1'b1);
            @(posedge clk); #1;
            check("hold_valid", 32'(m_ov), 32'd1);
            check("hold_ready", 32'(m_ir), 32'd0);
            check("hold_sum", m_sum, es);
            check("hold_flags", {29'd0, m_co, m_of, m_z}, {29'd0, ec, eo, ez});
        end
        set_iv(1'b0);
        ordy = 1'b1;
        check("done_ready_low", 32'(m_ir), 32'd0);
        @(posedge clk); #1;
        ordy = 1'b0;
        check("release_valid", 32'(m_ov), 32'd0);
        check("release_ready", 32'(m_ir), 32'd1);
    endtask

    task automatic mid_reset(input int sel);
        cur = sel;
        wait_ready();
        a = 32'h1234_5678; b = 32'h0FED_CBA9; sub = 1'b0;
        set_iv(1'b1);
        @(posedge clk); #1;
        set_iv(1'b0);
        if (sel == 0) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(m_ir), 32'd0);
        @(posedge clk); #1;
        check("rst_in_ready_held", 32'(m_ir), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(m_ov), 32'd0);
        check("abort_sum", m_sum, 32'd0);
        check("abort_flags", {29'd0, m_co, m_of, m_z}, 32'd0);
        check("abort_ready", 32'(m_ir), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale_valid", 32'(m_ov), 32'd0);
        end
        run_op(sel, 32'd1, 32'd1, 1'b0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] edges [6];
        edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h8000_0000;
        edges[3] = 32'h7FFF_FFFF; edges[4] = 32'h0000_0001; edges[5] = 32'h0000_00FF;
        cur = 0;
        rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; ordy = 1'b0; a = '0; b = '0; sub = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_in_ready", {31'd0, ir0 | ir1}, 32'd0);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            check("reset_valid", 32'(m_ov), 32'd0);
            check("reset_sum", m_sum, 32'd0);
            check("reset_flags", {29'd0, m_co, m_of, m_z}, 32'd0);
            check("reset_ready", 32'(m_ir), 32'd1);
        end

        for (int d = 0; d < 2; d++) begin
            run_op(d, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
            run_op(d, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
            run_op(d, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
            run_op(d, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
            run_op(d, 32'd5, 32'd7, 1'b1, 0);
            run_op(d, 32'd7, 32'd5, 1'b1, 0);
            run_op(d, 32'h8000_0000, 32'd1, 1'b1, 0);
            run_op(d, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 3);
            run_op(d, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, 0);
            mid_reset(d);
        end

        for (int i = 0; i < 200; i++) begin
            logic [31:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            run_op(int'($urandom_range(0, 1)), x, y, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
